// File: rtl/sha256_kconst_seq.sv
// SHA-256 round-constant sequencer.
// Once the RAM preload is complete, a START request streams K[0..ROUNDS-1]
// out of RAM to the compression core over a valid/ready handshake. Reads are
// issued ahead into a two-entry in-order buffer, so with K_READY held high
// one constant is delivered every cycle.
module sha256_kconst_seq #(
  parameter int unsigned       ADDR_W = 15,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       ROUNDS = 64,
  parameter logic [ADDR_W-1:0] K_BASE = '0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      INIT_COMPLETE,
  input  logic                      START,
  output logic [ADDR_W-1:0]         RAM_ADDR,
  output logic                      RAM_EN_N,
  input  logic [DATA_W-1:0]         RAM_DATA,
  output logic [DATA_W-1:0]         K_DATA,
  output logic [$clog2(ROUNDS)-1:0] K_ROUND,
  output logic                      K_LAST,
  output logic                      K_VALID,
  input  logic                      K_READY,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ABORT
);

  localparam int unsigned      CNT_W    = $clog2(ROUNDS);
  // The issue counter needs one extra bit so it can reach ROUNDS and stop.
  localparam logic [CNT_W:0]   ROUNDS_C = (CNT_W+1)'(ROUNDS);
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS-1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  fl_rnd_q, fl_rnd_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [CNT_W-1:0]  head_rnd_q, head_rnd_d, tail_rnd_q, tail_rnd_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_en_n_q, ram_en_n_d;
  logic              busy_q, busy_d, done_q, done_d, abort_q, abort_d;

  logic              k_valid, k_last, inflight, xfer, do_issue;
  logic [1:0]        occ_next;

  // RAM word address of constant idx; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] rd_addr(input logic [CNT_W:0] idx);
    return K_BASE + ADDR_W'(idx);
  endfunction

  assign k_valid  = (buf_cnt_q != 2'd0);
  assign k_last   = k_valid && (head_rnd_q == LAST_RND);
  // A read is in flight during exactly the cycle its enable is low.
  assign inflight = ~ram_en_n_q;
  assign xfer     = k_valid && K_READY;
  // Occupancy seen at the next edge, counting the read now in flight.
  assign occ_next = buf_cnt_q + {1'b0, inflight} - {1'b0, xfer};
  assign do_issue = (state_q == ST_RUN) && INIT_COMPLETE &&
                    (issue_cnt_q < ROUNDS_C) && (occ_next < 2'd2);

  // Next-state, read-issue and buffer push/pop decisions.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    fl_rnd_d    = fl_rnd_q;
    buf_cnt_d   = buf_cnt_q;
    head_data_d = head_data_q;
    head_rnd_d  = head_rnd_q;
    tail_data_d = tail_data_q;
    tail_rnd_d  = tail_rnd_q;
    ram_addr_d  = ram_addr_q;
    ram_en_n_d  = 1'b1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && INIT_COMPLETE) begin
          state_d     = ST_RUN;
          busy_d      = 1'b1;
          issue_cnt_d = '0;
          buf_cnt_d   = 2'd0;
        end
      end

      ST_RUN: begin
        if (!INIT_COMPLETE) begin
          // Preload invalidated: drop buffered words and the in-flight read.
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          abort_d   = 1'b1;
          buf_cnt_d = 2'd0;
        end else begin
          case ({inflight, xfer})
            2'b10: begin
              if (buf_cnt_q == 2'd0) begin
                head_data_d = RAM_DATA;
                head_rnd_d  = fl_rnd_q;
              end else begin
                tail_data_d = RAM_DATA;
                tail_rnd_d  = fl_rnd_q;
              end
              buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
              head_data_d = tail_data_q;
              head_rnd_d  = tail_rnd_q;
              buf_cnt_d   = buf_cnt_q - 2'd1;
            end
            2'b11: begin
              if (buf_cnt_q == 2'd1) begin
                head_data_d = RAM_DATA;
                head_rnd_d  = fl_rnd_q;
              end else begin
                head_data_d = tail_data_q;
                head_rnd_d  = tail_rnd_q;
                tail_data_d = RAM_DATA;
                tail_rnd_d  = fl_rnd_q;
              end
            end
            default: ;
          endcase

          if (do_issue) begin
            ram_en_n_d  = 1'b0;
            ram_addr_d  = rd_addr(issue_cnt_q);
            fl_rnd_d    = issue_cnt_q[CNT_W-1:0];
            issue_cnt_d = issue_cnt_q + 1'b1;
          end

          if (xfer && k_last) begin
            state_d = ST_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      ST_FINISH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // All state, buffer and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      fl_rnd_q    <= '0;
      buf_cnt_q   <= 2'd0;
      head_data_q <= '0;
      head_rnd_q  <= '0;
      tail_data_q <= '0;
      tail_rnd_q  <= '0;
      ram_addr_q  <= '0;
      ram_en_n_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      fl_rnd_q    <= fl_rnd_d;
      buf_cnt_q   <= buf_cnt_d;
      head_data_q <= head_data_d;
      head_rnd_q  <= head_rnd_d;
      tail_data_q <= tail_data_d;
      tail_rnd_q  <= tail_rnd_d;
      ram_addr_q  <= ram_addr_d;
      ram_en_n_q  <= ram_en_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign RAM_ADDR = ram_addr_q;
  assign RAM_EN_N = ram_en_n_q;
  assign K_DATA   = head_data_q;
  assign K_ROUND  = head_rnd_q;
  assign K_LAST   = k_last;
  assign K_VALID  = k_valid;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ABORT    = abort_q;

endmodule

// File: tb/tb_sha256_kconst_seq.sv
// Bench for sha256_kconst_seq: cycle table for start-up/stall behaviour,
// then full passes (ready-high, random ready), abort, async reset and
// address wrap on a second instance with K_BASE near the top of RAM.
module tb_sha256_kconst_seq;

  logic        CLK, RST_N, INIT_COMPLETE, START, K_READY;
  logic [14:0] RAM_ADDR;
  logic        RAM_EN_N;
  logic [31:0] RAM_DATA, K_DATA;
  logic [5:0]  K_ROUND;
  logic        K_LAST, K_VALID, BUSY, DONE, ABORT;

  logic        start_w, ready_w;
  logic [14:0] RAM_ADDR_w;
  logic        RAM_EN_N_w;
  logic [31:0] RAM_DATA_w, K_DATA_w;
  logic [5:0]  K_ROUND_w;
  logic        K_LAST_w, K_VALID_w, BUSY_w, DONE_w, ABORT_w;

  logic [31:0] kt [64];
  logic [31:0] mem [32768];

  int n_checks = 0;
  int n_fail   = 0;

  assign RAM_DATA   = mem[RAM_ADDR];
  assign RAM_DATA_w = {17'b0, RAM_ADDR_w};

  sha256_kconst_seq #(.ADDR_W(15), .DATA_W(32), .ROUNDS(64), .K_BASE(15'h0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .INIT_COMPLETE(INIT_COMPLETE), .START(START),
    .RAM_ADDR(RAM_ADDR), .RAM_EN_N(RAM_EN_N), .RAM_DATA(RAM_DATA),
    .K_DATA(K_DATA), .K_ROUND(K_ROUND), .K_LAST(K_LAST), .K_VALID(K_VALID),
    .K_READY(K_READY), .BUSY(BUSY), .DONE(DONE), .ABORT(ABORT));

  sha256_kconst_seq #(.ADDR_W(15), .DATA_W(32), .ROUNDS(64), .K_BASE(15'h7FF0)) dut_w (
    .CLK(CLK), .RST_N(RST_N), .INIT_COMPLETE(INIT_COMPLETE), .START(start_w),
    .RAM_ADDR(RAM_ADDR_w), .RAM_EN_N(RAM_EN_N_w), .RAM_DATA(RAM_DATA_w),
    .K_DATA(K_DATA_w), .K_ROUND(K_ROUND_w), .K_LAST(K_LAST_w), .K_VALID(K_VALID_w),
    .K_READY(ready_w), .BUSY(BUSY_w), .DONE(DONE_w), .ABORT(ABORT_w));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_pass();
    START = 1'b1;
    step();
    START = 1'b0;
    chk("start_busy", BUSY, 1);
    chk("start_valid", K_VALID, 0);
    chk("start_en_n", RAM_EN_N, 1);
  endtask

  // Drives K_READY and scoreboards one pass until DONE.
  task automatic run_pass(input bit rnd_ready, input int exp0, input int issued0,
                          output int cycles, output int first_valid);
    int          exp_r, issued, xferred;
    bit          pv, pl, pen, finished;
    logic [31:0] pd;
    logic [5:0]  prd;
    exp_r = exp0; issued = issued0; xferred = exp0;
    cycles = 0; first_valid = -1; finished = 0;
    while (!finished && cycles < 1000) begin
      K_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = K_VALID; pd = K_DATA; prd = K_ROUND; pl = K_LAST; pen = RAM_EN_N;
      if (!pen) begin
        issued++;
        chk("outstanding_le_2", (issued - xferred) <= 2, 1);
      end
      step();
      cycles++;
      if (first_valid < 0 && K_VALID) first_valid = cycles;
      if (pv && K_READY) begin
        chk("xfer_round", prd, exp_r);
        chk("xfer_data", pd, kt[exp_r]);
        chk("xfer_last", pl, exp_r == 63);
        xferred++;
        if (exp_r == 63) begin
          chk("done_pulse", DONE, 1);
          chk("done_busy", BUSY, 0);
          finished = 1;
        end
        exp_r++;
      end else if (pv) begin
        chk("stall_valid", K_VALID, 1);
        chk("stall_data", K_DATA, pd);
        chk("stall_round", K_ROUND, prd);
      end
    end
    if (!finished) chk("pass_timeout", 0, 1);
    chk("reads_issued", issued, 64);
    step();
    chk("done_one_cycle", DONE, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_valid", K_VALID, 0);
  endtask

  typedef struct {
    logic        init, start, ready;
    logic        en_n;
    logic [14:0] addr;
    logic        valid;
    logic [5:0]  rnd;
    logic        busy;
  } vec_t;

  vec_t vt [14];

  initial begin
    int          cyc, fv, guard, n;
    bit          hit, pv, pen;
    logic [31:0] pd;
    logic [5:0]  prd;
    logic [14:0] pa, ea;

    kt = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
           32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
           32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
           32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
           32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
           32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
           32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
           32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = kt[i];

    // init start ready | en_n addr valid round busy
    vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 15'd0, 1'b0, 6'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 15'd0, 1'b0, 6'd0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 15'd0, 1'b0, 6'd0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 6'd0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 15'd1, 1'b1, 6'd0, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 15'd1, 1'b1, 6'd0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 15'd1, 1'b1, 6'd0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 15'd2, 1'b1, 6'd1, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 15'd3, 1'b1, 6'd2, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 15'd4, 1'b1, 6'd3, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 15'd4, 1'b1, 6'd3, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 15'd4, 1'b1, 6'd3, 1'b1};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 15'd4, 1'b1, 6'd3, 1'b1};
    vt[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 15'd5, 1'b1, 6'd4, 1'b1};

    RST_N = 1'b0; INIT_COMPLETE = 1'b0; START = 1'b0; K_READY = 1'b0;
    start_w = 1'b0; ready_w = 1'b1;
    #12;
    chk("rst_en_n", RAM_EN_N, 1);
    chk("rst_addr", RAM_ADDR, 0);
    chk("rst_valid", K_VALID, 0);
    chk("rst_data", K_DATA, 0);
    chk("rst_round", K_ROUND, 0);
    chk("rst_last", K_LAST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_abort", ABORT, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    // Start-up, stall at two buffered words, release, START while busy.
    for (int i = 0; i < 14; i++) begin
      INIT_COMPLETE = vt[i].init; START = vt[i].start; K_READY = vt[i].ready;
      step();
      chk($sformatf("vec%0d_en_n", i), RAM_EN_N, vt[i].en_n);
      chk($sformatf("vec%0d_addr", i), RAM_ADDR, vt[i].addr);
      chk($sformatf("vec%0d_valid", i), K_VALID, vt[i].valid);
      chk($sformatf("vec%0d_busy", i), BUSY, vt[i].busy);
      chk($sformatf("vec%0d_done", i), DONE, 0);
      chk($sformatf("vec%0d_abort", i), ABORT, 0);
      if (vt[i].valid) begin
        chk($sformatf("vec%0d_round", i), K_ROUND, vt[i].rnd);
        chk($sformatf("vec%0d_data", i), K_DATA, kt[vt[i].rnd]);
        chk($sformatf("vec%0d_last", i), K_LAST, 0);
      end
    end
    START = 1'b0;
    run_pass(1'b0, 4, 5, cyc, fv);

    // Back-to-back pass: first valid two edges after start, 64 consecutive transfers.
    start_pass();
    run_pass(1'b0, 0, 0, cyc, fv);
    chk("latency_first_valid", fv, 2);
    chk("pass_cycles", cyc, 66);

    // Random backpressure pass.
    start_pass();
    run_pass(1'b1, 0, 0, cyc, fv);

    // Abort after round 10 is transferred.
    K_READY = 1'b1;
    start_pass();
    hit = 0; guard = 0;
    while (!hit && guard < 200) begin
      pv = K_VALID; prd = K_ROUND;
      step();
      guard++;
      if (pv && prd == 6'd10) hit = 1;
    end
    chk("abort_reach_r10", hit, 1);
    INIT_COMPLETE = 1'b0; K_READY = 1'b0;
    step();
    chk("abort_valid", K_VALID, 0);
    chk("abort_pulse", ABORT, 1);
    chk("abort_busy", BUSY, 0);
    chk("abort_en_n", RAM_EN_N, 1);
    chk("abort_no_done", DONE, 0);
    step();
    chk("abort_one_cycle", ABORT, 0);
    chk("abort_no_done2", DONE, 0);
    chk("abort_valid2", K_VALID, 0);
    INIT_COMPLETE = 1'b1; K_READY = 1'b1;
    start_pass();
    run_pass(1'b0, 0, 0, cyc, fv);
    chk("restart_first_valid", fv, 2);

    // Asynchronous reset between edges in mid-pass.
    start_pass();
    repeat (5) step();
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", K_VALID, 0);
    chk("arst_data", K_DATA, 0);
    chk("arst_round", K_ROUND, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_en_n", RAM_EN_N, 1);
    chk("arst_addr", RAM_ADDR, 0);
    #2;
    RST_N = 1'b1;
    repeat (3) begin
      step();
      chk("arst_no_resume_busy", BUSY, 0);
      chk("arst_no_resume_en_n", RAM_EN_N, 1);
    end

    // Address wrap on the K_BASE=0x7FF0 instance (its RAM returns the address).
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    n = 0; hit = 0; guard = 0;
    while (!hit && guard < 200) begin
      pen = RAM_EN_N_w; pa = RAM_ADDR_w; pv = K_VALID_w; pd = K_DATA_w; prd = K_ROUND_w;
      if (!pen) begin
        ea = 15'h7FF0 + 15'(n);
        chk("wrap_addr", pa, ea);
        n++;
      end
      step();
      guard++;
      if (pv) begin
        ea = 15'h7FF0 + 15'(prd);
        chk("wrap_data", pd, {17'b0, ea});
        if (prd == 6'd63) chk("wrap_last", K_LAST_w == 1'b0 && DONE_w == 1'b1, 1);
      end
      if (DONE_w) hit = 1;
    end
    chk("wrap_done", hit, 1);
    chk("wrap_reads", n, 64);
    chk("wrap_busy", BUSY_w, 0);
    chk("wrap_abort", ABORT_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_kconst_seq.md
Name: sha256_kconst_seq

Overview:
- Downstream consumer of the memory-manager stage.
- After the ROM-to-RAM preload signals INIT_COMPLETE, this block streams the 64 SHA-256 round constants K[0..63] out of RAM to the compression core, one per round.
- Output uses a valid/ready handshake.
- RAM reads are pipelined with a two-entry buffer, so sustained throughput is one constant per cycle while the consumer keeps K_READY high.

Parameters:
- ADDR_W, 15: RAM address width.
- DATA_W, 32: constant word width.
- ROUNDS, 64: constants per block; counter width is ceil(log2(ROUNDS)) = 6.
- K_BASE, 0: RAM word address of K[0].

Ports:
- CLK  in  1: single clock; all state changes on rising edge.
- RST_N  in  1: asynchronous, active-low reset.
- INIT_COMPLETE  in  1: high when the RAM preload is finished; level-sensitive.
- START  in  1: request one 64-constant pass; sampled on CLK.
- RAM_ADDR  out  ADDR_W: RAM read address, registered.
- RAM_EN_N  out  1: active-low RAM chip enable, registered; write enable is not driven by this block.
- RAM_DATA  in  DATA_W: RAM read data, valid one cycle after the address/enable cycle.
- K_DATA  out  DATA_W: current constant.
- K_ROUND  out  6: round index of K_DATA.
- K_LAST  out  1: high with K_VALID when K_ROUND == ROUNDS-1.
- K_VALID  out  1: K_DATA/K_ROUND/K_LAST valid.
- K_READY  in  1: consumer accepts; transfer = K_VALID & K_READY at a rising edge.
- BUSY  out  1: pass in progress.
- DONE  out  1: one-cycle pulse after the last transfer.
- ABORT  out  1: one-cycle pulse when a pass is killed by INIT_COMPLETE dropping.

Behaviour:
- Reset (RST_N low, async):
  - RAM_EN_N=1, RAM_ADDR=0.
  - K_VALID=0, K_DATA=0, K_ROUND=0, K_LAST=0.
  - BUSY=0, DONE=0, ABORT=0.
  - Buffer, in-flight flag and counters cleared.
  - Deassertion takes effect at the next CLK edge.
- States:
  - IDLE: START && INIT_COMPLETE at edge → RUN, BUSY=1. START with INIT_COMPLETE=0 is ignored.
  - RUN: issue reads and present words (rules below). On the transfer with K_LAST=1 → FINISH.
  - FINISH: DONE=1 for exactly one cycle, BUSY=0, → IDLE.
- Read issue:
  - issue_cnt counts 0..ROUNDS-1.
  - A read is issued in a cycle when: in RUN, issue_cnt < ROUNDS, and (buffered + inflight - xfer) < 2.
  - buffered = 0..2; inflight = 0..1; xfer = current-cycle transfer.
  - Issued read: RAM_EN_N=0 and RAM_ADDR=K_BASE+issue_cnt in that cycle (registered, so decided at the prior edge). issue_cnt increments.
  - RAM_EN_N=1 in every non-issue cycle.
- Capture:
  - RAM_DATA is written into the buffer at the edge ending the issue cycle, tagged with its round index.
  - Buffer is in-order FIFO of depth 2. The head drives K_DATA/K_ROUND/K_LAST; K_VALID = buffer non-empty.
  - Simultaneous capture and transfer: head pops, new word pushes, occupancy unchanged.
- Latency:
  - START accepted at edge E.
  - First issue in cycle E+1.
  - K_VALID=1 after edge E+2.
  - With K_READY held high, K_VALID stays high for 64 consecutive cycles, K_ROUND 0..63.
  - DONE is high in the cycle after the round-63 transfer.
- Backpressure:
  - With K_READY=0, K_DATA/K_ROUND/K_LAST are held stable.
  - At most 2 words are buffered, and no read is issued while full.
  - Never drop or duplicate a round.
- Address: RAM_ADDR wraps modulo 2^ADDR_W if K_BASE+63 overflows; no error.
- START while BUSY: ignored; no restart, no queueing.
- INIT_COMPLETE drops while BUSY:
  - Next edge: flush the buffer, discard any in-flight read, K_VALID=0, RAM_EN_N=1.
  - ABORT=1 for one cycle, BUSY=0 → IDLE. DONE is not asserted.
- START and INIT_COMPLETE rising in the same cycle: accepted (level sampled at that edge).
- Reset mid-pass: immediate return to reset values; the pass is not resumed.

Test Plan:
- Preload RAM[K_BASE+i] with standard K (K[0]=0x428a2f98, K[63]=0xc67178f2). INIT_COMPLETE=1, pulse START, K_READY=1 → K_VALID first high 2 edges after START; 64 back-to-back transfers with correct words and K_ROUND 0..63; K_LAST only on 0xc67178f2; DONE single pulse next cycle; BUSY low after.
- START with INIT_COMPLETE=0 → no RAM_EN_N low, BUSY stays 0. Raise INIT_COMPLETE, pulse START → normal pass.
- K_READY random (~50%) for a full pass → sequence still 0..63 in order; K_DATA stable while stalled; RAM_EN_N low exactly 64 cycles total; never more than 2 reads outstanding+buffered.
- K_READY=0 from START → exactly 2 reads issued (addr K_BASE, K_BASE+1), then RAM_EN_N stays 1. Release K_READY → rounds 0,1,2… resume without gaps.
- Drop INIT_COMPLETE after round 10 transfer → next cycle K_VALID=0, ABORT=1 one cycle, no DONE. New START after re-raise → restarts at round 0.
- Assert RST_N=0 asynchronously mid-pass (between edges) → outputs hit reset values immediately. Pulse START mid-pass (no reset) → ignored, pass completes normally. K_BASE=0x7FF0 → addresses wrap to 0x0000 after 0x7FFF.
